// File: rtl/isb_pf_queue.sv
// -----------------------------------------------------------------------------
// isb_pf_queue
// Prefetch issue queue placed directly after the ISB prefetcher. It filters
// prefetch candidates (duplicates and candidates already covered by demand
// traffic), buffers up to DEPTH requests, issues them over a valid/ready
// handshake tagged with the entry index, and frees an entry on the matching
// response.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   pf_v, pf_addr        prefetch candidate
//   demand_v, demand_addr demand access used for cancel / hit detection
//   mem_req_v/addr/tag   request presented to memory, held stable while stalled
//   mem_req_rdy          memory accepts the presented request
//   mem_resp_v/tag       response for a previously issued request
//   pf_hit               registered pulse, demand matched an issued/presented entry
//   drop_cnt             saturating count of candidates dropped on a full queue
//   occ, full            registered occupancy (non-FREE entries) and full flag
// -----------------------------------------------------------------------------
module isb_pf_queue #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 16,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pf_v,
    input  logic [AW-1:0] pf_addr,
    input  logic          demand_v,
    input  logic [AW-1:0] demand_addr,
    output logic          mem_req_v,
    output logic [AW-1:0] mem_req_addr,
    output logic [TW-1:0] mem_req_tag,
    input  logic          mem_req_rdy,
    input  logic          mem_resp_v,
    input  logic [TW-1:0] mem_resp_tag,
    output logic          pf_hit,
    output logic [7:0]    drop_cnt,
    output logic [TW:0]   occ,
    output logic          full
);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_INFL = 2'd2;

    // Entry storage
    logic [1:0]    st_reg    [DEPTH];
    logic [AW-1:0] addr_reg  [DEPTH];
    logic [1:0]    st_next   [DEPTH];
    logic [AW-1:0] addr_next [DEPTH];

    // Presented-entry select register and registered outputs
    logic          sel_v_reg,    sel_v_next;
    logic [TW-1:0] sel_idx_reg,  sel_idx_next;
    logic [AW-1:0] req_addr_reg, req_addr_next;
    logic          pf_hit_reg,   pf_hit_next;
    logic [7:0]    drop_cnt_reg, drop_cnt_next;
    logic [TW:0]   occ_reg,      occ_next;
    logic          full_reg,     full_next;

    // Per-entry decode vectors
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] dup_vec;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] cancel_vec;
    logic [DEPTH-1:0] resp_vec;
    logic [DEPTH-1:0] fire_vec;
    logic [DEPTH-1:0] alloc_vec;
    logic [DEPTH-1:0] pend_next_vec;
    logic [DEPTH-1:0] live_next_vec;

    logic          fire;
    logic          accept;
    logic          alloc_en;
    logic          drop_full;
    logic [TW-1:0] alloc_idx;
    logic          pend_any;
    logic [TW-1:0] pend_idx;

    assign fire = sel_v_reg & mem_req_rdy;

    // Candidate filtering is judged against registered state only, so a slot
    // freed this cycle (response or cancel) is not visible to the allocator.
    assign accept    = pf_v & ~(|dup_vec) & ~(demand_v & (demand_addr == pf_addr));
    assign alloc_en  = accept & (|free_vec);
    assign drop_full = accept & ~(|free_vec);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic live;
            logic presented;
            logic dmatch;

            assign live      = (st_reg[gi] != ST_FREE);
            assign presented = sel_v_reg & (sel_idx_reg == TW'(gi));
            assign dmatch    = demand_v & live & (addr_reg[gi] == demand_addr);

            assign free_vec[gi]   = ~live;
            assign dup_vec[gi]    = live & (addr_reg[gi] == pf_addr);
            // The presented entry is never cancelled: it is already on the bus.
            assign hit_vec[gi]    = dmatch & ((st_reg[gi] == ST_INFL) | presented);
            assign cancel_vec[gi] = dmatch & (st_reg[gi] == ST_PEND) & ~presented;
            assign resp_vec[gi]   = mem_resp_v & (mem_resp_tag == TW'(gi)) &
                                    (st_reg[gi] == ST_INFL);
            assign fire_vec[gi]   = fire & presented;
            assign alloc_vec[gi]  = alloc_en & (alloc_idx == TW'(gi));

            // The four events act on disjoint source states, so at most one
            // of them applies to an entry in any cycle.
            assign st_next[gi] = alloc_vec[gi]                   ? ST_PEND :
                                 fire_vec[gi]                    ? ST_INFL :
                                 (cancel_vec[gi] | resp_vec[gi]) ? ST_FREE :
                                                                   st_reg[gi];
            assign addr_next[gi] = alloc_vec[gi] ? pf_addr : addr_reg[gi];

            assign pend_next_vec[gi] = (st_next[gi] == ST_PEND);
            assign live_next_vec[gi] = (st_next[gi] != ST_FREE);
        end
    endgenerate

    // Lowest-index FREE entry (registered state)
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx = TW'(i);
            end
        end
    end

    // Lowest-index PEND entry of the next state; includes an entry being
    // allocated this edge, which gives the one-cycle pf_v to mem_req_v latency.
    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pend_next_vec[i]) begin
                pend_any = 1'b1;
                pend_idx = TW'(i);
            end
        end
    end

    // Select update: only re-choose after a fire or when nothing is presented,
    // so a stalled request keeps its address and tag.
    always_comb begin
        sel_v_next    = sel_v_reg;
        sel_idx_next  = sel_idx_reg;
        req_addr_next = req_addr_reg;
        if (!sel_v_reg || fire) begin
            sel_v_next = pend_any;
            if (pend_any) begin
                sel_idx_next  = pend_idx;
                req_addr_next = addr_next[pend_idx];
            end
        end
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + (TW + 1)'(live_next_vec[i]);
        end
        full_next = (occ_next == (TW + 1)'(DEPTH));
    end

    assign pf_hit_next   = |hit_vec;
    assign drop_cnt_next = (drop_full && drop_cnt_reg != 8'hFF) ? drop_cnt_reg + 8'd1
                                                                : drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_reg[i]   <= ST_FREE;
                addr_reg[i] <= '0;
            end
            sel_v_reg    <= 1'b0;
            sel_idx_reg  <= '0;
            req_addr_reg <= '0;
            pf_hit_reg   <= 1'b0;
            drop_cnt_reg <= '0;
            occ_reg      <= '0;
            full_reg     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_reg[i]   <= st_next[i];
                addr_reg[i] <= addr_next[i];
            end
            sel_v_reg    <= sel_v_next;
            sel_idx_reg  <= sel_idx_next;
            req_addr_reg <= req_addr_next;
            pf_hit_reg   <= pf_hit_next;
            drop_cnt_reg <= drop_cnt_next;
            occ_reg      <= occ_next;
            full_reg     <= full_next;
        end
    end

    assign mem_req_v    = sel_v_reg;
    assign mem_req_addr = req_addr_reg;
    assign mem_req_tag  = sel_idx_reg;
    assign pf_hit       = pf_hit_reg;
    assign drop_cnt     = drop_cnt_reg;
    assign occ          = occ_reg;
    assign full         = full_reg;

endmodule

// File: doc/isb_pf_queue.md
# isb_pf_queue

Prefetch issue queue sitting directly downstream of the ISB prefetcher. It captures `prefetch_v`/`prefetch_addr` candidates, drops duplicates and candidates overtaken by demand traffic, buffers up to DEPTH requests, and issues them to the memory side over a valid/ready handshake. Each request carries a tag. The matching response frees the entry.

## Interface
- DEPTH, 4, number of queue entries; power of two, at least 2
- AW, 16, address width; matches the ISB physical address width
- TW, log2(DEPTH), tag width (derived, not overridable)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pf_v  in  1  prefetch candidate valid (from ISB `prefetch_v`)
- pf_addr  in  AW  prefetch candidate address
- demand_v  in  1  demand access valid (same stream that trains the ISB)
- demand_addr  in  AW  demand address
- mem_req_v  out  1  prefetch request valid
- mem_req_addr  out  AW  prefetch request address
- mem_req_tag  out  TW  entry index of the request
- mem_req_rdy  in  1  memory accepts request; fire = mem_req_v & mem_req_rdy
- mem_resp_v  in  1  response for a previously issued request
- mem_resp_tag  in  TW  tag of that response
- pf_hit  out  1  registered pulse: a demand matched a prefetch already issued or being issued
- drop_cnt  out  8  saturating count of candidates dropped because the queue was full
- occ  out  TW+1  number of non-FREE entries
- full  out  1  occ == DEPTH

## Operation
- Each entry holds state {FREE, PEND, INFL} and addr[AW-1:0].
- **Accept.** On `pf_v`, evaluate in priority order against registered state:
  - drop silently if `pf_addr` equals the addr of any PEND/INFL entry;
  - drop silently if `demand_v` is high and `demand_addr == pf_addr`;
  - drop and increment `drop_cnt` (saturating at 255) if no entry is FREE;
  - otherwise write the lowest-index FREE entry as PEND.
- **Issue.** The presented entry is the lowest-index PEND entry, latched in a select register.
  - `mem_req_v` is high while a presented entry exists.
  - While `mem_req_v & !mem_req_rdy`, `mem_req_addr` and `mem_req_tag` hold stable. A new lowest-PEND choice is made only after a fire, or when nothing is presented.
  - On fire, the entry goes PEND->INFL.
- **Demand cancel.** `demand_v` matching a PEND entry that is not presented sets that entry FREE; no pf_hit.
- **Demand hit.** `demand_v` matching an INFL entry, or the presented entry, sets `pf_hit` the next cycle. The entry is unchanged; the presented entry still issues.
- **Response.** `mem_resp_v` with a tag whose entry is INFL sets that entry FREE. A response for a FREE or PEND entry is ignored.
- **Same-cycle events.**
  - A slot freed by a response or a cancel is not allocatable until the next cycle.
  - An allocation and a fire in the same cycle are independent.
  - A response and a fire on different tags both take effect.
- `occ` and `full` are registered and reflect entry state after each edge.

## Timing
- Reset (async assert, sync-safe deassert): all entries FREE, select empty.
  - `mem_req_v` = 0, `mem_req_addr` = 0, `mem_req_tag` = 0.
  - `pf_hit` = 0, `drop_cnt` = 0, `occ` = 0, `full` = 0.
- Reset mid-operation discards all PEND/INFL entries. Responses arriving after reset are ignored.
- Latency from `pf_v` (edge N) to `mem_req_v` high is 1 cycle (high after edge N) when the queue is idle.
- Back-to-back fires are possible every cycle while PEND entries exist.
- `pf_hit` is high exactly one cycle per matching demand, in the cycle after `demand_v`.
- Response-to-reallocation of the same slot takes 1 cycle minimum.

## Test plan
- **Basic issue.** Reset, rdy=1; `pf_v` addr 0x1000 -> next cycle `mem_req_v`=1, addr 0x1000, tag 0. Then INFL, `occ`=1. Response tag 0 -> `occ`=0.
- **Full and stall.** rdy=0; `pf_v` addrs 0x10, 0x20, 0x30, 0x40, 0x50 -> `full`=1 after the 4th, `drop_cnt`=1. `mem_req_addr` holds 0x10 for every stalled cycle.
- **Duplicate filter.** Two `pf_v` 0x2000 on consecutive cycles -> `occ`=1, `drop_cnt`=0.
- **Demand cancel and hit.** rdy=0; PEND 0x10 (presented) and 0x20; demand 0x20 -> entry 1 FREE, `pf_hit`=0. Demand 0x10 -> `pf_hit`=1 one cycle later, 0x10 still issues on rdy.
- **Same-cycle response.** Full queue; response tag 2 plus `pf_v` 0x99 in the same cycle -> 0x99 dropped, `drop_cnt`+1. 0x99 presented the next cycle is accepted into entry 2.
- **Reset mid-flight.** Two INFL entries, then `rst_n` pulse -> all outputs reset. A later response tag 0 changes nothing; `occ` stays 0.
